multicycle_cpu: RTL
===================

# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle core: executes the same MIPS subset (LW, SW, J, JAL, JR, BEQ, BNE, XORI, ADDI, ADD, SUB, SLT) through an explicit state machine over one shared instruction/data memory port with a ready handshake. It tolerates variable-latency memory, halts on illegal or misaligned operations, and exposes a retired-instruction counter for test benches. It sits at the top of the CPU hierarchy and replaces the separate ifetch/memory arrangement.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, width of mem_addr; byte address = low ADDR_W bits of the computed address
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write (SW), 0 = read (fetch or LW)
- mem_addr  out  ADDR_W  byte address, always word aligned when mem_req=1
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid in the cycle mem_req & mem_ready
- mem_ready  in  1  memory accepts/completes the transfer this cycle
- halted  out  1  core stopped (illegal opcode/funct or misaligned access)
- retired  out  32  count of completed instructions, wraps at 2^32
- state  out  3  current FSM state, debug only

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC; wait while !mem_ready; on ready latch IR, PC<=PC+4, go DECODE.
- DECODE: read Rs/Rt into A/B. J: PC<={PC[31:28],target,2'b00}. JAL: same, plus $31<=PC (already +4). JR: PC<=A; A[1:0]!=0 -> HALT. Jumps retire here -> FETCH. Unknown opcode/funct -> HALT. Otherwise -> EXEC.
- EXEC: ALU. ADD/SUB 32-bit wrap, overflow ignored; SLT signed; ADDI sign-extends imm; XORI zero-extends imm. BEQ/BNE: compare A/B; taken -> PC<=PC+(sext(imm)<<2); retire -> FETCH. LW/SW: address=A+sext(imm); address[1:0]!=0 -> HALT; else -> MEM. Others -> WB.
- MEM: mem_req=1, mem_addr=address, mem_we=SW, mem_wdata=B; wait for ready. SW retires -> FETCH; LW latches rdata -> WB.
- WB: R-type writes Rd, ADDI/XORI/LW write Rt; retire -> FETCH.
- Writes to $0 are discarded; $0 always reads 0.
- HALT: mem_req=0, halted=1, no further register/PC/counter change until rst_n low.

## Timing
- Reset (async assert, sync-released): PC=RESET_PC, state=FETCH, mem_req=0 during reset, halted=0, retired=0, registers=0.
- mem_req, mem_addr, mem_we, mem_wdata are registered-stable from first request cycle until the cycle mem_ready is sampled high; never withdrawn early. mem_ready with mem_req=0 is ignored.
- Zero-wait memory latencies: J/JAL/JR 2 cycles; BEQ/BNE 3; ADD/SUB/SLT/ADDI/XORI/SW 4; LW 5. Each wait cycle adds one.
- retired increments in the final cycle of each instruction; visible the following cycle.
- Reset asserted mid-transfer aborts immediately; no partial write is issued after rst_n low.
- Branch/jump to the same PC (self-loop) is legal and runs indefinitely.

## Structure
- Shared package cpu_pkg: opcode/funct constants, state enum, ALU command encoding, RESET_PC default.
- Reuse existing regfile for the 32x32 register file.
- One new sub-module multicycle_control: state machine, next-state and per-state control signals; datapath (PC, IR, A, B, ALUOut, MDR, muxes) stays in the top.

## Test plan
- Reset: rst_n low with PC reset 0x100 -> first mem_req=1, mem_addr=0x100, retired=0, halted=0.
- ADDI $1,$0,5; ADDI $2,$0,7; ADD $3,$1,$2; SLT $4,$1,$2, ready tied 1 -> $3=12, $4=1, retired=4 after 16 cycles.
- SW $3,0x40($0) then LW $5,0x40($0) with 2-wait-state memory -> mem_wdata=12 at 0x40, $5=12, request signals stable through waits.
- BNE $1,$2,-1 at 0x10 -> PC returns to 0x10; BEQ $1,$1,+2 at 0x20 -> next fetch 0x2C.
- JAL 0x40 at 0x08 then JR $31 -> $31=0x0C, fetch at 0x100 then 0x0C.
- Opcode 0x3F, or LW from 0x41 -> halted=1, mem_req stays 0, retired frozen; rst_n pulse clears halted.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and datapath control encodings shared by the multicycle core
package cpu_pkg;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} alu_t;
  typedef enum logic [1:0] {PC_INC, PC_JUMP, PC_REG, PC_BR} pc_src_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_t;
  typedef enum logic [1:0] {WD_ALU, WD_MDR, WD_PC} wd_t;
  function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_R ? (fn inside {FN_JR, FN_ADD, FN_SUB, FN_SLT})
                      : (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW});
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: instruction sequencer and per-state datapath enables
module multicycle_control import cpu_pkg::*; (
  input  logic      clk,
  input  logic      rst_n,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic      mem_ready,
  input  logic      eq,
  input  logic      jr_bad,
  input  logic      addr_bad,
  output state_t    state,
  output logic      mem_req,
  output logic      mem_we,
  output logic      ir_we,
  output logic      pc_we,
  output pc_src_t   pc_src,
  output logic      alu_we,
  output logic      mdr_we,
  output logic      rf_we,
  output dst_t      rf_dst,
  output wd_t       rf_wd,
  output alu_t      alu_cmd,
  output logic      retire
);
  state_t next;
  logic mem_op;
  assign mem_op = op == OP_LW || op == OP_SW;
  // bus request is killed combinationally by reset so no transfer survives rst_n low
  assign mem_req = rst_n && (state == FETCH || state == MEM);
  assign mem_we = rst_n && state == MEM && op == OP_SW;
  assign alu_cmd = op == OP_XORI ? ALU_XOR : op != OP_R ? ALU_ADD :
                   fn == FN_SUB ? ALU_SUB : fn == FN_SLT ? ALU_SLT : ALU_ADD;
  assign rf_dst = op == OP_JAL ? DST_RA : op == OP_R ? DST_RD : DST_RT;
  assign rf_wd = op == OP_JAL ? WD_PC : op == OP_LW ? WD_MDR : WD_ALU;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  // next state and enables; HALT and unused encodings hold everything still
  always_comb begin
    next = state;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_INC;
    alu_we = 1'b0;
    mdr_we = 1'b0;
    rf_we = 1'b0;
    retire = 1'b0;
    case (state)
      FETCH: if (mem_ready) begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        next = DECODE;
      end
      DECODE:
        if (!legal(op, fn)) next = HALT;
        else if (op == OP_J || op == OP_JAL) begin
          pc_we = 1'b1;
          pc_src = PC_JUMP;
          rf_we = op == OP_JAL;
          retire = 1'b1;
          next = FETCH;
        end else if (op == OP_R && fn == FN_JR) begin
          pc_we = !jr_bad;
          pc_src = PC_REG;
          retire = !jr_bad;
          next = jr_bad ? HALT : FETCH;
        end else next = EXEC;
      EXEC:
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_we = eq ^ (op == OP_BNE);
          pc_src = PC_BR;
          retire = 1'b1;
          next = FETCH;
        end else begin
          alu_we = !(mem_op && addr_bad);
          next = !mem_op ? WB : addr_bad ? HALT : MEM;
        end
      MEM: if (mem_ready) begin
        mdr_we = op == OP_LW;
        retire = op == OP_SW;
        next = op == OP_SW ? FETCH : WB;
      end
      WB: begin
        rf_we = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      default: next = HALT;
    endcase
  end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, two combinational read ports, one write port, $0 reads zero
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] r [32];
  // write port; writes aimed at $0 are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) r[i] <= '0;
    else if (we && wa != 5'd0) r[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : r[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : r[ra2];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: MIPS-subset core sequenced over a single shared memory port with ready handshake
module multicycle_cpu import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       retired,
  output logic [2:0]        state
);
  state_t st;
  pc_src_t pc_src;
  dst_t rf_dst;
  wd_t rf_wd;
  alu_t alu_cmd;
  logic ir_we, pc_we, alu_we, mdr_we, rf_we, retire;
  logic [31:0] pc, ir, a, b, alu_out, mdr, rd1, rd2, sext, opb, alu_y, pc_next, wd;
  logic [4:0] wa;
  multicycle_control u_ctrl (
    .clk(clk), .rst_n(rst_n), .op(ir[31:26]), .fn(ir[5:0]), .mem_ready(mem_ready),
    .eq(a == b), .jr_bad(|rd1[1:0]), .addr_bad(|alu_y[1:0]), .state(st),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_we(alu_we), .mdr_we(mdr_we), .rf_we(rf_we), .rf_dst(rf_dst), .rf_wd(rf_wd),
    .alu_cmd(alu_cmd), .retire(retire)
  );
  regfile u_rf (
    .clk(clk), .rst_n(rst_n), .ra1(ir[25:21]), .ra2(ir[20:16]),
    .we(rf_we), .wa(wa), .wd(wd), .rd1(rd1), .rd2(rd2)
  );
  assign sext = {{16{ir[15]}}, ir[15:0]};
  assign opb = ir[31:26] == OP_R ? b : ir[31:26] == OP_XORI ? {16'h0, ir[15:0]} : sext;
  assign alu_y = alu_cmd == ALU_SUB ? a - opb :
                 alu_cmd == ALU_SLT ? {31'h0, $signed(a) < $signed(opb)} :
                 alu_cmd == ALU_XOR ? a ^ opb : a + opb;
  // pc already points past the instruction when jumps and branches resolve
  assign pc_next = pc_src == PC_JUMP ? {pc[31:28], ir[25:0], 2'b00} :
                   pc_src == PC_REG ? rd1 :
                   pc_src == PC_BR ? pc + {sext[29:0], 2'b00} : pc + 32'd4;
  assign wa = rf_dst == DST_RA ? 5'd31 : rf_dst == DST_RD ? ir[15:11] : ir[20:16];
  assign wd = rf_wd == WD_PC ? pc : rf_wd == WD_MDR ? mdr : alu_out;
  assign mem_addr = ADDR_W'(st == FETCH ? pc : alu_out);
  assign mem_wdata = b;
  assign halted = st == HALT;
  assign state = st;
  // datapath registers; operands latched in DECODE, address/result in EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      retired <= '0;
    end else begin
      if (ir_we) ir <= mem_rdata;
      if (pc_we) pc <= pc_next;
      if (st == DECODE) a <= rd1;
      if (st == DECODE) b <= rd2;
      if (alu_we) alu_out <= alu_y;
      if (mdr_we) mdr <= mem_rdata;
      if (retire) retired <= retired + 32'd1;
    end
endmodule
